// File: rtl/bless_inject_pkg.sv
// ============================================================================
// bless_inject_pkg : shared constants and helpers for the BLESS injection port
// Revision 1.0
// ============================================================================
`default_nettype none

`ifndef WIDTH_PORT
`define WIDTH_PORT 16
`endif

package bless_inject_pkg;

   localparam int FLIT_W       = `WIDTH_PORT;
   localparam int NUM_NEIGH    = 4;
   localparam int INJ_CNT_W    = 16;
   localparam int STARVE_CNT_W = 8;

   function automatic logic [2:0] popcount4(input logic [NUM_NEIGH-1:0] bits);
      logic [2:0] sum;
      sum = '0;
      for (int i = 0; i < NUM_NEIGH; i++) begin
         sum = sum + {2'b00, bits[i]};
      end
      return sum;
   endfunction

endpackage

`default_nettype wire

// File: rtl/bless_inject_ctrl_if.sv
// ============================================================================
// bless_inject_ctrl_if : PE handshake, neighbour links and status of the port
// Revision 1.0
// ============================================================================
`default_nettype none

interface bless_inject_ctrl_if #(
   parameter int FLIT_W = bless_inject_pkg::FLIT_W,
   parameter int DEPTH  = 4
);
   import bless_inject_pkg::*;

   logic                    pe_valid;
   logic [FLIT_W-1:0]       pe_flit;
   logic                    pe_ready;
   logic [FLIT_W-1:0]       link_w;
   logic [FLIT_W-1:0]       link_e;
   logic [FLIT_W-1:0]       link_s;
   logic [FLIT_W-1:0]       link_n;
   logic [FLIT_W-1:0]       inj_flit;
   logic [$clog2(DEPTH):0]  fifo_count;
   logic [INJ_CNT_W-1:0]    inj_cnt;
   logic                    starve;

   // Controller side
   modport slave (
      input  pe_valid, pe_flit, link_w, link_e, link_s, link_n,
      output pe_ready, inj_flit, fifo_count, inj_cnt, starve
   );

   // PE / router environment side
   modport master (
      output pe_valid, pe_flit, link_w, link_e, link_s, link_n,
      input  pe_ready, inj_flit, fifo_count, inj_cnt, starve
   );

endinterface

`default_nettype wire

// File: rtl/bless_inject_fifo.sv
// ============================================================================
// bless_inject_fifo : power-of-2 flit FIFO with registered head and occupancy
// Revision 1.0
// ============================================================================
`default_nettype none

module bless_inject_fifo #(
   parameter int FLIT_W = 16,
   parameter int DEPTH  = 4
) (
   input  wire logic                   clk,
   input  wire logic                   reset,
   input  wire logic                   push_i,
   input  wire logic [FLIT_W-1:0]      din_i,
   input  wire logic                   pop_i,
   output      logic [FLIT_W-1:0]      head_o,
   output      logic [$clog2(DEPTH):0] count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [FLIT_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q;
   logic [AW-1:0]     rd_ptr_q;
   logic [AW:0]       count_q;
   logic [AW:0]       count_d;

   always_comb begin
      count_d = count_q;
      case ({push_i, pop_i})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Pointers wrap for free because DEPTH is a power of two.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) begin
            mem_q[wr_ptr_q] <= din_i;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (pop_i) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         count_q <= count_d;
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/bless_inject_ctrl.sv
// ============================================================================
// bless_inject_ctrl : BLESS local-port injection controller (FIFO + grant)
// Optional starvation flag enabled by defining BLESS_INJ_STARVE_EN.
// Revision 1.0
// ============================================================================
`default_nettype none

module bless_inject_ctrl
   import bless_inject_pkg::*;
#(
   parameter int FLIT_W       = bless_inject_pkg::FLIT_W,
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 16
) (
   input wire logic           clk,
   input wire logic           reset,
   bless_inject_ctrl_if.slave bus
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
       STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_param_check
      $error("bless_inject_ctrl: illegal DEPTH or STARVE_LIMIT");
   end

   logic [FLIT_W-1:0]    head_w;
   logic [CNT_W-1:0]     count_w;
   logic [NUM_NEIGH-1:0] busy_w;
   logic [2:0]           occ_w;
   logic                 ready_w;
   logic                 push_w;
   logic                 grant_w;
   logic [INJ_CNT_W-1:0] inj_cnt_q;

   assign busy_w  = {bus.link_n != '0, bus.link_s != '0,
                     bus.link_e != '0, bus.link_w != '0};
   assign occ_w   = popcount4(busy_w);

   // Readiness looks only at registered occupancy, so a same-cycle pop
   // never opens a slot for a push into a full FIFO.
   assign ready_w = (count_w != CNT_W'(DEPTH));
   assign push_w  = bus.pe_valid && ready_w && (bus.pe_flit != '0);
   assign grant_w = (count_w != '0) && (occ_w < 3'(NUM_NEIGH));

   bless_inject_fifo #(
      .FLIT_W (FLIT_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push_w),
      .din_i   (bus.pe_flit),
      .pop_i   (grant_w),
      .head_o  (head_w),
      .count_o (count_w)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         inj_cnt_q <= '0;
      end else if (grant_w && (inj_cnt_q != '1)) begin
         inj_cnt_q <= inj_cnt_q + 1'b1;
      end
   end

`ifdef BLESS_INJ_STARVE_EN
   logic [STARVE_CNT_W-1:0] starve_cnt_q;
   logic [STARVE_CNT_W-1:0] starve_cnt_inc_w;
   logic                    starve_q;

   assign starve_cnt_inc_w = starve_cnt_q + 1'b1;

   // A blocked cycle is a non-empty FIFO without grant; the counter sticks at
   // its maximum rather than wrapping back under the limit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         starve_cnt_q <= '0;
         starve_q     <= 1'b0;
      end else if (grant_w) begin
         starve_cnt_q <= '0;
         starve_q     <= 1'b0;
      end else if (count_w == '0) begin
         starve_cnt_q <= '0;
      end else begin
         if (starve_cnt_q != '1) begin
            starve_cnt_q <= starve_cnt_inc_w;
         end
         if (starve_cnt_inc_w == STARVE_CNT_W'(STARVE_LIMIT)) begin
            starve_q <= 1'b1;
         end
      end
   end

   assign bus.starve = starve_q;
`else
   assign bus.starve = 1'b0;
`endif

   assign bus.pe_ready   = ready_w;
   assign bus.inj_flit   = grant_w ? head_w : '0;
   assign bus.fifo_count = count_w;
   assign bus.inj_cnt    = inj_cnt_q;

endmodule

`default_nettype wire

// File: doc/bless_inject_ctrl.md
# bless_inject_ctrl

Local-port injection controller for the bufferless BLESS router. It queues flits from the processing element (PE) in a small FIFO. It drives the router's local input only when one of the four neighbour-link output ports is guaranteed free, which is the case when fewer than four neighbour links carry a flit this cycle. It also keeps injection statistics and optionally flags starvation. It sits between the PE and the router's `dinLocal` input.

## Interface
- `FLIT_W`, default `` `WIDTH_PORT ``: flit width; the all-zero flit is the idle encoding.
- `DEPTH`, default 4: FIFO entries; must be a power of 2, ≥2.
- `STARVE_LIMIT`, default 16: consecutive blocked cycles before `starve` asserts; range 1..255.
- `clk`, in, 1: single clock; all state is updated on the rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `pe_valid`, in, 1: PE offers `pe_flit`.
- `pe_flit`, in, FLIT_W: flit from the PE.
- `pe_ready`, out, 1: controller can accept a flit.
- `link_w`, `link_e`, `link_s`, `link_n`, in, FLIT_W each: same-cycle neighbour flits feeding the router's W/E/S/N inputs. A nonzero value means the link is occupied.
- `inj_flit`, out, FLIT_W: drives router `dinLocal`; 0 means no injection.
- `fifo_count`, out, $clog2(DEPTH)+1: current FIFO occupancy.
- `inj_cnt`, out, 16: saturating count of injected flits.
- `starve`, out, 1: starvation flag.

## Operation
- Push: occurs when `pe_valid && pe_ready && pe_flit != 0`.
  - `pe_valid` with `pe_flit == 0` is ignored. Nothing is enqueued and the ready status is unaffected.
- `pe_ready = (fifo_count != DEPTH)`. It is derived from registered occupancy only.
  - A pop in the same cycle does not free a slot for a push when full.
- `occ` = popcount of the four `link_x != 0` conditions.
- `grant = (fifo_count != 0) && (occ < 4)`.
- `inj_flit = grant ? head : 0`. This path is combinational from the head register and the link inputs.
- Pop: occurs on every cycle with `grant`.
  - Push and pop in the same cycle are both performed; `fifo_count` is unchanged.
- FIFO order is strict FIFO. Pointers wrap modulo DEPTH.
- There is no bypass: a flit pushed at edge k is first eligible in the cycle after edge k.
- `inj_cnt` increments by 1 per grant and saturates at 0xFFFF.
- Reset, including mid-operation:
  - FIFO flushed and pointers zeroed; queued flits are discarded.
  - `fifo_count=0`, `inj_cnt=0`, `starve=0`.
  - Consequently `pe_ready=1` and `inj_flit=0`.

## Timing
- Injection latency: a flit pushed at edge k reaches `inj_flit` in cycle k+1 at the earliest, assuming the FIFO was empty and `occ<4`. The router registers it at edge k+1.
- Blocked cycle: `occ==4` with FIFO non-empty.
  - `inj_flit=0`, the head is held, and no state changes except the starvation counter.
- Full FIFO: `pe_ready=0` for the whole cycle. The PE must hold `pe_valid` and `pe_flit` until `pe_ready` is high.
- Back-to-back: with `occ<4` every cycle and continuous PE supply, one flit is injected per cycle at steady state.
- Empty FIFO: `inj_flit=0` regardless of `occ`.

## Configuration
- `BLESS_INJ_STARVE_EN` defined:
  - An 8-bit counter increments on each blocked cycle and clears on any grant or when the FIFO is empty.
  - `starve` is registered. It asserts at the edge where the counter reaches STARVE_LIMIT and stays high until the edge at which a grant occurs.
- `BLESS_INJ_STARVE_EN` undefined: the counter logic is absent and `starve` is tied to 0.

## Structure
- Shared package `bless_inject_pkg` holds:
  - `FLIT_W` derived from `` `WIDTH_PORT ``;
  - `NUM_NEIGH=4`;
  - `INJ_CNT_W=16`;
  - `STARVE_CNT_W=8`.
- One sub-module, `bless_inject_fifo`:
  - parameterised by FLIT_W and DEPTH;
  - interface: push/pop/head/count;
  - no internal checks; the wrapper guarantees it never pushes when full or pops when empty.
- The top holds the occupancy popcount, grant logic, `inj_cnt` and the optional starvation logic.

## Test plan
- Reset then idle:
  - `fifo_count=0`, `pe_ready=1`, `inj_flit=0`, `inj_cnt=0`, `starve=0`.
  - Assert `reset` mid-stream with 3 flits queued; outputs return to these values immediately.
- Single flit:
  - Push 0x00A5 at edge 1 with all links 0.
  - `inj_flit=0x00A5` in cycle 2; `fifo_count` reads 1 in cycle 2 and 0 after edge 2; `inj_cnt=1`.
- Fill and block:
  - Hold all four links nonzero and push 4 flits 0x1..0x4.
  - `fifo_count=4`, `pe_ready=0`, `inj_flit=0`.
  - Drop `link_n` to 0; flits 0x1, 0x2, 0x3, 0x4 are injected in consecutive cycles, in order.
- Simultaneous push/pop at count 2 with `occ=3`:
  - Count stays 2 and the head advances.
  - At count 4 with the PE still valid, no push occurs while popping.
- Zero flit: `pe_valid=1`, `pe_flit=0` for 5 cycles; `fifo_count` stays 0 and `inj_cnt` stays 0.
- Starvation (macro defined, STARVE_LIMIT=16):
  - 1 flit queued, all links busy for 20 cycles; `starve` rises after the 16th blocked cycle.
  - Free one link; the flit is injected and `starve` falls at that edge.
  - With the macro undefined, `starve` stays 0 throughout.
